aes_frame_sequencer: RTL and testbench
======================================

AES_FRAME_SEQUENCER -- requirements
Module: aes_frame_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, inter-byte receive timeout in CLK cycles (used only with AES_SEQ_TIMEOUT_EN).
REQ-002 CLK  in  1  system clock; all logic on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 rx_ready  in  1  one-cycle pulse per byte received by UART.
REQ-005 rx_data  in  8  received byte, valid while rx_ready=1.
REQ-006 tx_ready  in  1  UART transmitter idle, can accept a byte.
REQ-007 tx_data  out  8  byte to transmit, stable from tx_enable pulse until tx_ready next rises.
REQ-008 tx_enable  out  1  one-cycle pulse launching transmission of tx_data.
REQ-009 aes_key  out  128  key to AES core; first key byte received maps to [127:120].
REQ-010 aes_pt  out  128  plaintext to AES core; first byte maps to [127:120].
REQ-011 aes_start  out  1  one-cycle pulse starting encryption.
REQ-012 aes_done  in  1  one-cycle pulse; aes_ct valid in same cycle.
REQ-013 aes_ct  in  128  ciphertext from AES core.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 key_valid  out  1  high once a complete key has been loaded.
REQ-016 overrun  out  1  sticky; set when rx_ready arrives in a state not accepting bytes.

Function
REQ-017 States: IDLE, RX_KEY, RX_PT, START, WAIT_AES, TX_LOAD, TX_WAIT.
REQ-018 IDLE: rx_ready with 0x4B ('K') -> RX_KEY; 0x45 ('E') -> RX_PT; any other byte -> queue reply 0x3F, go TX_LOAD.
REQ-019 RX_KEY/RX_PT: 4-bit byte counter; each rx_ready shifts rx_data into the low byte of a 128-bit shift register (left shift by 8).
REQ-020 After 16th key byte: copy shift register to aes_key, set key_valid, queue single reply 0x4B, go TX_LOAD.
REQ-021 After 16th plaintext byte: if key_valid, copy to aes_pt, go START; else queue single reply 0x21 ('!'), go TX_LOAD.
REQ-022 START: aes_start=1 for exactly one cycle, then WAIT_AES.
REQ-023 WAIT_AES: on aes_done, capture aes_ct into TX buffer, queue 16-byte reply, go TX_LOAD; no timeout.
REQ-024 TX_LOAD: when tx_ready=1, drive tx_data with next byte (ciphertext MSB first), pulse tx_enable one cycle, go TX_WAIT.
REQ-025 TX_WAIT: wait until tx_ready observed 0, then until 1; then next byte -> TX_LOAD, or after last byte -> IDLE.
REQ-026 tx_enable never asserted while tx_ready=0; at most one pulse per byte.
REQ-027 rx_ready in START, WAIT_AES, TX_LOAD, TX_WAIT: byte discarded, overrun set; state unaffected.
REQ-028 Key load while key_valid=1 overwrites aes_key only at 16th byte; partial reload leaves old key in use.
REQ-029 aes_done outside WAIT_AES ignored.

Reset
REQ-030 On RST: state IDLE, tx_enable=0, aes_start=0, tx_data=0, aes_key=0, aes_pt=0, busy=0, key_valid=0, overrun=0, counters=0.
REQ-031 RST mid-frame or mid-transmission aborts immediately; no further tx_enable or aes_start until new command.

Configuration
REQ-032 Macro AES_SEQ_TIMEOUT_EN defined: in RX_KEY/RX_PT a counter restarts on each rx_ready; reaching TIMEOUT_CYCLES discards partial frame, queues reply 0x54 ('T'), goes TX_LOAD; key_valid and aes_key unchanged.
REQ-033 Macro undefined: no timeout counter; RX_KEY/RX_PT wait indefinitely.

Structure
REQ-034 Shared package aes_seq_pkg holds state enum, command codes (0x4B, 0x45), reply codes (0x3F, 0x21, 0x4B, 0x54), frame length 16.
REQ-035 One sub-module aes_seq_tx_ser: 128-bit buffer, byte count, tx_ready/tx_enable handshake (TX_LOAD/TX_WAIT logic).

Verification
REQ-036 'K' + bytes 0x00..0x0F -> aes_key=0x000102...0F, key_valid=1, one tx byte 0x4B.
REQ-037 After key load, 'E' + 16 bytes 0x11 -> aes_pt=0x11..11, one aes_start pulse; model aes_done with ct=0xA0A1..AF -> tx bytes A0,A1,...,AF in order, then busy=0.
REQ-038 Reset, then 'E' + 16 bytes -> no aes_start, single tx byte 0x21.
REQ-039 Byte 0x55 in IDLE -> single tx 0x3F; bytes sent during WAIT_AES -> overrun=1, ciphertext unchanged.
REQ-040 With AES_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100: 'K' + 5 bytes, then 100 idle cycles -> tx 0x54, key_valid unchanged.
REQ-041 RST asserted during 8th ciphertext byte -> all outputs at reset values next cycle, no further tx_enable.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the UART-fronted AES frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_KEY,
        RX_PT,
        START,
        WAIT_AES,
        TX_LOAD,
        TX_WAIT
    } seq_state_t;

    // Command bytes accepted in IDLE
    localparam logic [7:0] CMD_KEY     = 8'h4B;  // 'K'
    localparam logic [7:0] CMD_ENC     = 8'h45;  // 'E'

    // Single-byte replies
    localparam logic [7:0] RPL_UNKNOWN = 8'h3F;  // '?'
    localparam logic [7:0] RPL_NO_KEY  = 8'h21;  // '!'
    localparam logic [7:0] RPL_KEY_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] RPL_TIMEOUT = 8'h54;  // 'T'

    localparam int         FRAME_LEN   = 16;
    localparam logic [3:0] LAST_IDX    = 4'(FRAME_LEN - 1);
    localparam logic [4:0] LEN_SINGLE  = 5'd1;
    localparam logic [4:0] LEN_FRAME   = 5'(FRAME_LEN);

    // A single-byte reply sits in the MSB lane, which is sent first.
    function automatic logic [127:0] single_reply(input logic [7:0] code);
        return {code, 120'd0};
    endfunction

endpackage

// File: rtl/aes_frame_sequencer_if.sv
// UART byte stream and AES core signals bundled for the frame sequencer.
// Latency: n/a (wiring only).
// Backpressure: tx_ready from the UART throttles tx_enable; rx side has none.
interface aes_frame_sequencer_if;
    logic         rx_ready;
    logic [7:0]   rx_data;
    logic         tx_ready;
    logic [7:0]   tx_data;
    logic         tx_enable;
    logic [127:0] aes_key;
    logic [127:0] aes_pt;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_ct;
    logic         busy;
    logic         key_valid;
    logic         overrun;

    // Sequencer side
    modport slave (
        input  rx_ready, rx_data, tx_ready, aes_done, aes_ct,
        output tx_data, tx_enable, aes_key, aes_pt, aes_start,
               busy, key_valid, overrun
    );

    // UART / AES core / environment side
    modport master (
        output rx_ready, rx_data, tx_ready, aes_done, aes_ct,
        input  tx_data, tx_enable, aes_key, aes_pt, aes_start,
               busy, key_valid, overrun
    );
endinterface

// File: rtl/aes_seq_tx_ser.sv
// Reply serializer: holds up to 16 bytes and feeds them MSB-first to the UART.
// Latency: tx_enable one cycle after TX_LOAD sees tx_ready high.
// Backpressure: launches only while tx_ready=1; waits for tx_ready low->high per byte.
module aes_seq_tx_ser
    import aes_seq_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [127:0] load_buf,
    input  logic [4:0]   load_len,
    input  logic         in_load,
    input  logic         in_wait,
    input  logic         tx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_enable,
    output logic         byte_done,
    output logic         last_byte
);

    logic [127:0] shreg;
    logic [4:0]   remaining;
    logic         seen_low;

    // Buffer load, byte launch and the low-phase tracker of the UART handshake
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shreg     <= '0;
            remaining <= '0;
            seen_low  <= 1'b0;
            tx_data   <= '0;
            tx_enable <= 1'b0;
        end else begin
            tx_enable <= 1'b0;
            if (load) begin
                shreg     <= load_buf;
                remaining <= (load_len > LEN_FRAME) ? LEN_FRAME : load_len;
                seen_low  <= 1'b0;
            end else if (in_load && tx_ready) begin
                tx_data   <= shreg[127:120];
                tx_enable <= 1'b1;
                shreg     <= {shreg[119:0], 8'h00};
                remaining <= remaining - 5'd1;
                seen_low  <= 1'b0;
            end else if (in_wait && !tx_ready) begin
                seen_low  <= 1'b1;
            end
        end
    end

    // A byte is finished once the UART went busy and came back idle.
    assign byte_done = in_wait & seen_low & tx_ready;
    assign last_byte = (remaining == 5'd0);

endmodule

// File: rtl/aes_frame_sequencer.sv
// Command sequencer between a UART and an AES core: loads key/plaintext frames, runs AES, returns replies.
// Latency: reply launch one cycle after entering TX_LOAD with tx_ready high; aes_start in the cycle after the 16th plaintext byte.
// Backpressure: UART tx_ready gates each reply byte; rx bytes arriving while busy are dropped and flag overrun. Optional AES_SEQ_TIMEOUT_EN adds an inter-byte receive timeout.
module aes_frame_sequencer
    import aes_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  CLK,
    input  logic                  RST,
    aes_frame_sequencer_if.slave  bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_t   state;
    logic [3:0]   byte_cnt;
    logic [127:0] shift_q;
    logic [127:0] next_shift;
    logic [127:0] aes_key_q;
    logic [127:0] aes_pt_q;
    logic         aes_start_q;
    logic         key_valid_q;
    logic         overrun_q;

    logic         reply_load;
    logic [127:0] reply_buf;
    logic [4:0]   reply_len;
    logic         rx_timeout;
    logic         in_rx;
    logic         ser_byte_done;
    logic         ser_last;

    assign next_shift = {shift_q[119:0], bus.rx_data};
    assign in_rx      = (state == RX_KEY) || (state == RX_PT);

`ifdef AES_SEQ_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    // Idle-cycle counter while a frame is being received; any byte restarts it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt <= '0;
        end else if (!in_rx || bus.rx_ready || rx_timeout) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign rx_timeout = in_rx && !bus.rx_ready && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign rx_timeout = 1'b0;
`endif

    // Decide which reply, if any, gets handed to the serializer this cycle
    always_comb begin
        reply_load = 1'b0;
        reply_buf  = single_reply(RPL_UNKNOWN);
        reply_len  = LEN_SINGLE;
        unique case (state)
            IDLE: begin
                if (bus.rx_ready && bus.rx_data != CMD_KEY && bus.rx_data != CMD_ENC) begin
                    reply_load = 1'b1;
                end
            end
            RX_KEY: begin
                if (bus.rx_ready && byte_cnt == LAST_IDX) begin
                    reply_load = 1'b1;
                    reply_buf  = single_reply(RPL_KEY_OK);
                end else if (rx_timeout) begin
                    reply_load = 1'b1;
                    reply_buf  = single_reply(RPL_TIMEOUT);
                end
            end
            RX_PT: begin
                if (bus.rx_ready && byte_cnt == LAST_IDX && !key_valid_q) begin
                    reply_load = 1'b1;
                    reply_buf  = single_reply(RPL_NO_KEY);
                end else if (rx_timeout) begin
                    reply_load = 1'b1;
                    reply_buf  = single_reply(RPL_TIMEOUT);
                end
            end
            WAIT_AES: begin
                if (bus.aes_done) begin
                    reply_load = 1'b1;
                    reply_buf  = bus.aes_ct;
                    reply_len  = LEN_FRAME;
                end
            end
            default: begin
                reply_load = 1'b0;
            end
        endcase
    end

    // Main sequencer FSM with its registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            shift_q     <= '0;
            aes_key_q   <= '0;
            aes_pt_q    <= '0;
            aes_start_q <= 1'b0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            aes_start_q <= 1'b0;
            if (bus.rx_ready && !(state == IDLE || in_rx)) begin
                overrun_q <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (bus.rx_ready) begin
                        byte_cnt <= '0;
                        shift_q  <= '0;
                        if (bus.rx_data == CMD_KEY) begin
                            state <= RX_KEY;
                        end else if (bus.rx_data == CMD_ENC) begin
                            state <= RX_PT;
                        end else begin
                            state <= TX_LOAD;
                        end
                    end
                end
                RX_KEY: begin
                    if (bus.rx_ready) begin
                        shift_q  <= next_shift;
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == LAST_IDX) begin
                            aes_key_q   <= next_shift;
                            key_valid_q <= 1'b1;
                            state       <= TX_LOAD;
                        end
                    end else if (rx_timeout) begin
                        byte_cnt <= '0;
                        state    <= TX_LOAD;
                    end
                end
                RX_PT: begin
                    if (bus.rx_ready) begin
                        shift_q  <= next_shift;
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == LAST_IDX) begin
                            if (key_valid_q) begin
                                aes_pt_q    <= next_shift;
                                aes_start_q <= 1'b1;
                                state       <= START;
                            end else begin
                                state <= TX_LOAD;
                            end
                        end
                    end else if (rx_timeout) begin
                        byte_cnt <= '0;
                        state    <= TX_LOAD;
                    end
                end
                START: begin
                    state <= WAIT_AES;
                end
                WAIT_AES: begin
                    if (bus.aes_done) begin
                        state <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    if (bus.tx_ready) begin
                        state <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (ser_byte_done) begin
                        state <= ser_last ? IDLE : TX_LOAD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    aes_seq_tx_ser u_tx_ser (
        .CLK       (CLK),
        .RST       (RST),
        .load      (reply_load),
        .load_buf  (reply_buf),
        .load_len  (reply_len),
        .in_load   (state == TX_LOAD),
        .in_wait   (state == TX_WAIT),
        .tx_ready  (bus.tx_ready),
        .tx_data   (bus.tx_data),
        .tx_enable (bus.tx_enable),
        .byte_done (ser_byte_done),
        .last_byte (ser_last)
    );

    assign bus.aes_key   = aes_key_q;
    assign bus.aes_pt    = aes_pt_q;
    assign bus.aes_start = aes_start_q;
    assign bus.key_valid = key_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_aes_frame_sequencer.sv
// Self-checking bench for aes_frame_sequencer with UART and AES core models.
// Latency: n/a (simulation only).
// Backpressure: the UART model holds tx_ready low for 1-4 cycles after every tx_enable.
module tb_aes_frame_sequencer;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    aes_frame_sequencer_if bus ();

    aes_frame_sequencer #(.TIMEOUT_CYCLES(100)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]   txq[$];
    int           tx_en_count = 0;
    int           start_count = 0;
    int           uart_cnt    = 0;
    int           aes_pend    = 0;
    int           aes_delay   = 3;
    logic [127:0] next_ct     = '0;

    // Reference state derived from the command history
    logic         model_kv;
    logic [127:0] model_key;
    logic [127:0] model_pt;

    // UART transmitter model: records bytes, goes busy for a few cycles per byte
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge CLK);
            if (bus.tx_enable === 1'b1) begin
                checks++;
                if (bus.tx_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL tx_enable_while_busy: tx_ready=%b required 1", bus.tx_ready);
                end
                txq.push_back(bus.tx_data);
                tx_en_count++;
                bus.tx_ready = 1'b0;
                uart_cnt = $urandom_range(1, 4);
            end else if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) bus.tx_ready = 1'b1;
            end
        end
    end

    // AES core model: answers each start with next_ct after aes_delay cycles
    initial begin
        bus.aes_done = 1'b0;
        bus.aes_ct   = '0;
        forever begin
            @(negedge CLK);
            if (bus.aes_done) bus.aes_done = 1'b0;
            if (bus.aes_start === 1'b1) begin
                start_count++;
                aes_pend = aes_delay;
            end else if (aes_pend > 0) begin
                aes_pend--;
                if (aes_pend == 0) begin
                    bus.aes_done = 1'b1;
                    bus.aes_ct   = next_ct;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        @(negedge CLK);
        bus.rx_ready = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [127:0] data);
        send_byte(cmd);
        for (int i = 0; i < 16; i++) send_byte(data[127 - 8*i -: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge CLK);
        while (!(bus.busy === 1'b0 && bus.tx_ready && uart_cnt == 0 && aes_pend == 0 && !bus.aes_done)
               && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_timeout: busy=%b required 0 within 3000 cycles", tag, bus.busy);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST          = 1'b1;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge CLK);
        uart_cnt     = 0;
        bus.tx_ready = 1'b1;
        aes_pend     = 0;
        RST          = 1'b0;
        @(negedge CLK);
        txq.delete();
        model_kv  = 1'b0;
        model_key = '0;
        model_pt  = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 8;
        if (bus.tx_enable !== 1'b0) begin failures++; $display("FAIL rst_tx_enable: got %b want 0", bus.tx_enable); end
        if (bus.aes_start !== 1'b0) begin failures++; $display("FAIL rst_aes_start: got %b want 0", bus.aes_start); end
        if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); end
        if (bus.aes_key !== 128'h0) begin failures++; $display("FAIL rst_aes_key: got %h want 0", bus.aes_key); end
        if (bus.aes_pt !== 128'h0) begin failures++; $display("FAIL rst_aes_pt: got %h want 0", bus.aes_pt); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        if (bus.key_valid !== 1'b0) begin failures++; $display("FAIL rst_key_valid: got %b want 0", bus.key_valid); end
        if (bus.overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun: got %b want 0", bus.overrun); end
    endtask

    task automatic test_key_load();
        logic [127:0] k = 128'h000102030405060708090A0B0C0D0E0F;
        txq.delete();
        send_frame(8'h4B, k);
        wait_idle("key_load");
        model_kv  = 1'b1;
        model_key = k;
        checks += 4;
        if (txq.size() != 1) begin failures++; $display("FAIL key_reply_count: got %0d want 1", txq.size()); end
        else if (txq[0] !== 8'h4B) begin failures++; $display("FAIL key_reply_byte: got %h want 4b", txq[0]); end
        if (bus.aes_key !== k) begin failures++; $display("FAIL key_value: got %h want %h", bus.aes_key, k); end
        if (bus.key_valid !== 1'b1) begin failures++; $display("FAIL key_valid: got %b want 1", bus.key_valid); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL key_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_encrypt();
        logic [127:0] pt = {16{8'h11}};
        int s0 = start_count;
        next_ct   = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
        aes_delay = $urandom_range(2, 6);
        txq.delete();
        send_frame(8'h45, pt);
        wait_idle("encrypt");
        model_pt = pt;
        checks += 5;
        if (bus.aes_pt !== pt) begin failures++; $display("FAIL enc_pt: got %h want %h", bus.aes_pt, pt); end
        if (start_count - s0 != 1) begin failures++; $display("FAIL enc_start_pulses: got %0d want 1", start_count - s0); end
        if (txq.size() != 16) begin failures++; $display("FAIL enc_reply_count: got %0d want 16", txq.size()); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL enc_busy: got %b want 0", bus.busy); end
        if (bus.overrun !== 1'b0) begin failures++; $display("FAIL enc_overrun: got %b want 0", bus.overrun); end
        for (int i = 0; i < 16 && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== next_ct[127 - 8*i -: 8]) begin
                failures++;
                $display("FAIL enc_ct_byte%0d: got %h want %h", i, txq[i], next_ct[127 - 8*i -: 8]);
            end
        end
    endtask

    task automatic test_overrun();
        logic [127:0] ct = rand128();
        int s0 = start_count;
        int n  = 0;
        next_ct   = ct;
        aes_delay = 40;
        txq.delete();
        send_frame(8'h45, rand128());
        while (start_count == s0 && n < 20) begin @(negedge CLK); n++; end
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        wait_idle("overrun");
        model_pt = bus.aes_pt;
        checks += 3;
        if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b want 1", bus.overrun); end
        if (txq.size() != 16) begin failures++; $display("FAIL ovr_reply_count: got %0d want 16", txq.size()); end
        if (bus.aes_key !== model_key) begin failures++; $display("FAIL ovr_key: got %h want %h", bus.aes_key, model_key); end
        for (int i = 0; i < 16 && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== ct[127 - 8*i -: 8]) begin
                failures++;
                $display("FAIL ovr_ct_byte%0d: got %h want %h", i, txq[i], ct[127 - 8*i -: 8]);
            end
        end
        aes_delay = 3;
    endtask

    task automatic test_partial_reload();
        logic [127:0] newk = rand128();
        logic [127:0] oldk = model_key;
        txq.delete();
        send_byte(8'h4B);
        for (int i = 0; i < 8; i++) send_byte(newk[127 - 8*i -: 8]);
        repeat (3) @(negedge CLK);
        checks += 2;
        if (bus.aes_key !== oldk) begin failures++; $display("FAIL partial_key_kept: got %h want %h", bus.aes_key, oldk); end
        if (bus.key_valid !== 1'b1) begin failures++; $display("FAIL partial_key_valid: got %b want 1", bus.key_valid); end
        for (int i = 8; i < 16; i++) send_byte(newk[127 - 8*i -: 8]);
        wait_idle("reload");
        model_key = newk;
        checks += 2;
        if (bus.aes_key !== newk) begin failures++; $display("FAIL reload_key: got %h want %h", bus.aes_key, newk); end
        if (txq.size() != 1 || txq[0] !== 8'h4B) begin
            failures++;
            $display("FAIL reload_reply: got %0d bytes first %h, want 1 byte 4b", txq.size(), txq.size() ? txq[0] : 8'h00);
        end
    endtask

    task automatic test_done_ignored();
        txq.delete();
        next_ct  = rand128();
        aes_pend = 3;
        repeat (10) @(negedge CLK);
        checks += 2;
        if (txq.size() != 0) begin failures++; $display("FAIL stray_done_reply: got %0d bytes want 0", txq.size()); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL stray_done_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_unknown();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] b;
            do b = 8'($urandom); while (b == 8'h4B || b == 8'h45);
            txq.delete();
            send_byte(b);
            wait_idle("unknown");
            checks++;
            if (txq.size() != 1 || txq[0] !== 8'h3F) begin
                failures++;
                $display("FAIL unknown_reply(%h): got %0d bytes first %h, want 1 byte 3f", b, txq.size(), txq.size() ? txq[0] : 8'h00);
            end
        end
    endtask

`ifdef AES_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [127:0] junk = rand128();
        txq.delete();
        send_byte(8'h4B);
        for (int i = 0; i < 5; i++) send_byte(junk[127 - 8*i -: 8]);
        wait_idle("timeout");
        checks += 3;
        if (txq.size() != 1 || txq[0] !== 8'h54) begin
            failures++;
            $display("FAIL timeout_reply: got %0d bytes first %h, want 1 byte 54", txq.size(), txq.size() ? txq[0] : 8'h00);
        end
        if (bus.key_valid !== model_kv) begin failures++; $display("FAIL timeout_key_valid: got %b want %b", bus.key_valid, model_kv); end
        if (bus.aes_key !== model_key) begin failures++; $display("FAIL timeout_key: got %h want %h", bus.aes_key, model_key); end
    endtask
`endif

    task automatic test_no_key();
        int s0;
        apply_reset();
        s0 = start_count;
        send_frame(8'h45, rand128());
        wait_idle("no_key");
        checks += 3;
        if (start_count != s0) begin failures++; $display("FAIL nokey_start: got %0d pulses want 0", start_count - s0); end
        if (txq.size() != 1 || txq[0] !== 8'h21) begin
            failures++;
            $display("FAIL nokey_reply: got %0d bytes first %h, want 1 byte 21", txq.size(), txq.size() ? txq[0] : 8'h00);
        end
        if (bus.aes_pt !== 128'h0) begin failures++; $display("FAIL nokey_pt: got %h want 0", bus.aes_pt); end
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 12; it++) begin
            logic [7:0]   expq[$];
            logic [127:0] data = rand128();
            int           kind = $urandom_range(0, 2);
            int           s0   = start_count;
            int           exp_starts = 0;
            logic [7:0]   b;
            txq.delete();
            expq.delete();
            if (kind == 0) begin
                send_frame(8'h4B, data);
                model_kv  = 1'b1;
                model_key = data;
                expq.push_back(8'h4B);
            end else if (kind == 1) begin
                next_ct   = rand128();
                aes_delay = $urandom_range(1, 8);
                send_frame(8'h45, data);
                if (model_kv) begin
                    model_pt   = data;
                    exp_starts = 1;
                    for (int i = 0; i < 16; i++) expq.push_back(next_ct[127 - 8*i -: 8]);
                end else begin
                    expq.push_back(8'h21);
                end
            end else begin
                do b = 8'($urandom); while (b == 8'h4B || b == 8'h45);
                send_byte(b);
                expq.push_back(8'h3F);
            end
            wait_idle("random");
            checks += 5;
            if (txq.size() != expq.size()) begin failures++; $display("FAIL rnd%0d_reply_count: got %0d want %0d", it, txq.size(), expq.size()); end
            else if (txq != expq) begin failures++; $display("FAIL rnd%0d_reply_bytes: first got %h want %h", it, txq[0], expq[0]); end
            if (bus.aes_key !== model_key) begin failures++; $display("FAIL rnd%0d_key: got %h want %h", it, bus.aes_key, model_key); end
            if (bus.key_valid !== model_kv) begin failures++; $display("FAIL rnd%0d_key_valid: got %b want %b", it, bus.key_valid, model_kv); end
            if (bus.aes_pt !== model_pt) begin failures++; $display("FAIL rnd%0d_pt: got %h want %h", it, bus.aes_pt, model_pt); end
            if (start_count - s0 != exp_starts) begin failures++; $display("FAIL rnd%0d_starts: got %0d want %0d", it, start_count - s0, exp_starts); end
        end
    endtask

    task automatic test_reset_mid_tx();
        int n = 0;
        int cyc = 0;
        int c0, s0;
        txq.delete();
        send_frame(8'h4B, rand128());
        wait_idle("rst_mid_key");
        next_ct   = rand128();
        aes_delay = 3;
        send_frame(8'h45, rand128());
        while (n < 8 && cyc < 2000) begin
            @(posedge CLK);
            #1;
            if (bus.tx_enable === 1'b1) n++;
            cyc++;
        end
        checks++;
        if (n < 8) begin failures++; $display("FAIL rstmid_reach_byte8: got %0d pulses want 8", n); end
        RST = 1'b1;
        @(negedge CLK);
        checks += 8;
        if (bus.tx_enable !== 1'b0) begin failures++; $display("FAIL rstmid_tx_enable: got %b want 0", bus.tx_enable); end
        if (bus.aes_start !== 1'b0) begin failures++; $display("FAIL rstmid_aes_start: got %b want 0", bus.aes_start); end
        if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL rstmid_tx_data: got %h want 00", bus.tx_data); end
        if (bus.aes_key !== 128'h0) begin failures++; $display("FAIL rstmid_aes_key: got %h want 0", bus.aes_key); end
        if (bus.aes_pt !== 128'h0) begin failures++; $display("FAIL rstmid_aes_pt: got %h want 0", bus.aes_pt); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        if (bus.key_valid !== 1'b0) begin failures++; $display("FAIL rstmid_key_valid: got %b want 0", bus.key_valid); end
        if (bus.overrun !== 1'b0) begin failures++; $display("FAIL rstmid_overrun: got %b want 0", bus.overrun); end
        c0 = tx_en_count;
        s0 = start_count;
        repeat (2) @(negedge CLK);
        uart_cnt     = 0;
        bus.tx_ready = 1'b1;
        RST          = 1'b0;
        model_kv  = 1'b0;
        model_key = '0;
        model_pt  = '0;
        repeat (200) @(negedge CLK);
        checks += 3;
        if (tx_en_count != c0) begin failures++; $display("FAIL rstmid_no_more_tx: got %0d extra pulses want 0", tx_en_count - c0); end
        if (start_count != s0) begin failures++; $display("FAIL rstmid_no_start: got %0d extra pulses want 0", start_count - s0); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle: busy=%b want 0", bus.busy); end
    endtask

    initial begin
        RST          = 1'b1;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_key_load();
        test_encrypt();
        test_overrun();
        test_partial_reload();
        test_done_ignored();
        test_unknown();
`ifdef AES_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_no_key();
        test_random_frames();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
